accum_request_sequencer: RTL and testbench

Frame-aligned request generator that sits directly upstream of the shift-accumulate RAM. It consumes a raster pixel stream of luma samples and classifies each pixel into a bit, 0, 1 or ambiguous. Over WIDTH consecutive frames it issues one accumulate request per pixel, so each RAM word builds up a WIDTH-bit blink code. It owns frame counting, pixel addressing and the choice of request type (WRITE_OVER / WRITE / DISABLE).

---
 rtl/accum_pkg.sv | 21 ++
 rtl/accum_request_sequencer_if.sv | 41 ++++
 rtl/luma_classifier.sv | 24 ++
 rtl/accum_request_sequencer.sv | 141 ++++++++++++++
 tb/tb_accum_request_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared request encoding for the shift-accumulate RAM and the blocks that
// feed it, plus the rule that turns a pixel class into a request type.
package accum_pkg;

  typedef enum logic [1:0] {
    READ       = 2'd0,
    WRITE      = 2'd1,
    WRITE_OVER = 2'd2,
    DISABLE    = 2'd3
  } accum_request_t;

  // Ambiguous pixels never touch the RAM word; the first frame of a code
  // overwrites whatever an earlier capture left behind, later frames shift in.
  function automatic accum_request_t select_request_type(input logic ambiguous,
                                                         input logic first_frame);
    if (ambiguous)        return DISABLE;
    else if (first_frame) return WRITE_OVER;
    else                  return WRITE;
  endfunction

endpackage

// File: rtl/accum_request_sequencer_if.sv
// Pixel stream in, accumulate requests out. The sequencer sits on the slave
// side: it consumes pixels and produces RAM requests.
interface accum_request_sequencer_if
  import accum_pkg::*;
#(
  parameter int DEPTH      = 57600,
  parameter int LUMA_WIDTH = 8
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  pixel_valid_in;
  logic [LUMA_WIDTH-1:0] pixel_luma_in;
  logic                  frame_start_in;

  logic [AW-1:0]         addr_out;
  logic                  summand_out;
  accum_request_t        request_type_out;
  logic                  request_valid_out;

  modport master (
    output pixel_valid_in,
    output pixel_luma_in,
    output frame_start_in,
    input  addr_out,
    input  summand_out,
    input  request_type_out,
    input  request_valid_out
  );

  modport slave (
    input  pixel_valid_in,
    input  pixel_luma_in,
    input  frame_start_in,
    output addr_out,
    output summand_out,
    output request_type_out,
    output request_valid_out
  );

endinterface

// File: rtl/luma_classifier.sv
// Combinational luma thresholding. The high test is evaluated first so that
// overlapping thresholds (lo >= hi) still give a definite 1.
module luma_classifier #(
  parameter int LUMA_WIDTH = 8
) (
  input  logic [LUMA_WIDTH-1:0] luma_in,
  input  logic [LUMA_WIDTH-1:0] thresh_lo_in,
  input  logic [LUMA_WIDTH-1:0] thresh_hi_in,
  output logic                  summand_out,
  output logic                  ambiguous_out
);

  logic hit_hi;
  logic hit_lo;

  // Classify: at/above hi is a 1, at/below lo is a 0, anything between is unusable.
  always_comb begin
    hit_hi        = (luma_in >= thresh_hi_in);
    hit_lo        = (luma_in <= thresh_lo_in);
    summand_out   = hit_hi;
    ambiguous_out = !hit_hi && !hit_lo;
  end

endmodule

// File: rtl/accum_request_sequencer.sv
// Frame-aligned request generator for the shift-accumulate RAM. Arms on
// start_in, aligns to the next frame start, then issues one request per pixel
// for WIDTH frames so every RAM word accumulates a WIDTH-bit blink code.
module accum_request_sequencer
  import accum_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 57600,
  parameter  int LUMA_WIDTH = 8,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [LUMA_WIDTH-1:0] thresh_lo_in,
  input  logic [LUMA_WIDTH-1:0] thresh_hi_in,
  accum_request_sequencer_if.slave bus,
  output logic                  busy_out,
  output logic [FW-1:0]         frame_idx_out,
  output logic                  done_out
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  // Address counter carries one extra bit so "past the end of the frame"
  // is representable and overlong frames can be dropped without wrapping.
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(WIDTH - 1);

  state_t      state;
  logic [AW:0] addr_cnt;
  logic        pix_summand;
  logic        pix_ambiguous;

  luma_classifier #(
    .LUMA_WIDTH (LUMA_WIDTH)
  ) u_classifier (
    .luma_in       (bus.pixel_luma_in),
    .thresh_lo_in  (thresh_lo_in),
    .thresh_hi_in  (thresh_hi_in),
    .summand_out   (pix_summand),
    .ambiguous_out (pix_ambiguous)
  );

  // Capture FSM: frame/pixel bookkeeping and the registered request outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                 <= IDLE;
      addr_cnt              <= '0;
      frame_idx_out         <= '0;
      busy_out              <= 1'b0;
      done_out              <= 1'b0;
      bus.addr_out          <= '0;
      bus.summand_out       <= 1'b0;
      bus.request_type_out  <= READ;
      bus.request_valid_out <= 1'b0;
    end else begin
      bus.request_valid_out <= 1'b0;
      bus.request_type_out  <= READ;
      bus.summand_out       <= 1'b0;
      done_out              <= 1'b0;

      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= ARMED;
            busy_out <= 1'b1;
          end
        end

        // Wait for a frame boundary so address 0 really is the first pixel.
        ARMED: begin
          if (bus.pixel_valid_in && bus.frame_start_in) begin
            bus.request_valid_out <= 1'b1;
            bus.addr_out          <= '0;
            bus.summand_out       <= pix_summand;
            bus.request_type_out  <= select_request_type(pix_ambiguous, 1'b1);
            frame_idx_out         <= '0;
            addr_cnt              <= (AW+1)'(1);
            if (LAST_FRAME == '0 && LAST_ADDR == '0) begin
              state    <= IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          if (bus.pixel_valid_in) begin
            if (bus.frame_start_in) begin
              if (frame_idx_out == LAST_FRAME) begin
                // A new frame while on the last one: finish with what we have.
                state    <= IDLE;
                busy_out <= 1'b0;
                done_out <= 1'b1;
              end else begin
                bus.request_valid_out <= 1'b1;
                bus.addr_out          <= '0;
                bus.summand_out       <= pix_summand;
                bus.request_type_out  <= select_request_type(pix_ambiguous, 1'b0);
                frame_idx_out         <= frame_idx_out + 1'b1;
                addr_cnt              <= (AW+1)'(1);
                if ((frame_idx_out + 1'b1) == LAST_FRAME && LAST_ADDR == '0) begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
                  done_out <= 1'b1;
                end
              end
            end else if (addr_cnt < DEPTH_C) begin
              bus.request_valid_out <= 1'b1;
              bus.addr_out          <= addr_cnt[AW-1:0];
              bus.summand_out       <= pix_summand;
              bus.request_type_out  <= select_request_type(pix_ambiguous,
                                                           frame_idx_out == '0);
              addr_cnt              <= addr_cnt + 1'b1;
              if (frame_idx_out == LAST_FRAME && addr_cnt[AW-1:0] == LAST_ADDR) begin
                state    <= IDLE;
                busy_out <= 1'b0;
                done_out <= 1'b1;
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_request_sequencer.sv
// Randomised bench for accum_request_sequencer: the stimulus process pushes
// the expected request for every pixel it drives; a negedge monitor pops and
// compares whenever the DUT presents a request or a done pulse.
module tb_accum_request_sequencer;
  import accum_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 8;
  localparam int LO    = 50;
  localparam int HI    = 200;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic [LW-1:0] thresh_lo_in = LW'(LO);
  logic [LW-1:0] thresh_hi_in = LW'(HI);
  logic          busy_out;
  logic [1:0]    frame_idx_out;
  logic          done_out;

  accum_request_sequencer_if #(.DEPTH(DEPTH), .LUMA_WIDTH(LW)) bus ();

  accum_request_sequencer #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .LUMA_WIDTH (LW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .thresh_lo_in  (thresh_lo_in),
    .thresh_hi_in  (thresh_hi_in),
    .bus           (bus.slave),
    .busy_out      (busy_out),
    .frame_idx_out (frame_idx_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit req;
    bit done;
    int addr;
    int summand;
    int rtype;
    int frame;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every request or done pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && (bus.request_valid_out || done_out)) begin
      if (done_out) done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: valid=%0b done=%0b addr=%0d, expected nothing (t=%0t)",
                 bus.request_valid_out, done_out, bus.addr_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("request_valid", 32'(bus.request_valid_out), 32'(e.req));
        check("done_pulse", 32'(done_out), 32'(e.done));
        if (e.req) begin
          check("addr", 32'(bus.addr_out), e.addr);
          check("summand", 32'(bus.summand_out), e.summand);
          check("request_type", 32'(bus.request_type_out), e.rtype);
          check("frame_idx", 32'(frame_idx_out), e.frame);
        end
      end
    end
  end

  // Reference: classify by threshold rules, then pick the request type.
  function automatic exp_t expect_px(input int f, input int i, input logic [LW-1:0] luma);
    exp_t e;
    bit   one;
    bit   zero;
    one       = (luma >= thresh_hi_in);
    zero      = !one && (luma <= thresh_lo_in);
    e.req     = 1'b1;
    e.addr    = i;
    e.summand = one ? 1 : 0;
    e.rtype   = (!one && !zero) ? 3 : ((f == 0) ? 2 : 1);
    e.frame   = f;
    e.done    = (f == WIDTH-1) && (i == DEPTH-1);
    return e;
  endfunction

  function automatic logic [LW-1:0] rand_luma();
    case ($urandom_range(0, 4))
      0:       return LW'($urandom_range(0, LO));
      1:       return LW'($urandom_range(HI, 255));
      2:       return LW'($urandom_range(LO+1, HI-1));
      3:       return LW'(LO);
      default: return LW'(HI);
    endcase
  endfunction

  // mode 0: bright frames 0/2, dark 1/3; mode 1: random; mode 2: random with
  // ambiguous/tie values planted at pixels 3..5 of frame 1.
  function automatic logic [LW-1:0] pick_luma(input int mode, input int f, input int i);
    if (mode == 0) return (f == 0 || f == 2) ? 8'd255 : 8'd0;
    if (mode == 2 && f == 1 && i == 3) return 8'd120;
    if (mode == 2 && f == 1 && i == 4) return 8'd200;
    if (mode == 2 && f == 1 && i == 5) return 8'd50;
    return rand_luma();
  endfunction

  task automatic drive(input bit v, input bit fs, input logic [LW-1:0] luma, input bit st);
    bus.pixel_valid_in = v;
    bus.frame_start_in = fs;
    bus.pixel_luma_in  = luma;
    start_in           = st;
    @(posedge clk_in);
    #1;
    bus.pixel_valid_in = 1'b0;
    bus.frame_start_in = 1'b0;
    start_in           = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.addr_out), 0);
    check({tag, "_summand"}, 32'(bus.summand_out), 0);
    check({tag, "_type"}, 32'(bus.request_type_out), 32'(READ));
    check({tag, "_valid"}, 32'(bus.request_valid_out), 0);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_frame_idx"}, 32'(frame_idx_out), 0);
    check({tag, "_done"}, 32'(done_out), 0);
  endtask

  task automatic run_capture(input string name, input int lens[WIDTH], input int mode,
                             input bit gaps, input int pre_px,
                             input int abort_frame, input int abort_px);
    int done_before;
    done_before = done_cnt;
    drive(1'b0, 1'b0, '0, 1'b1);
    check({name, "_busy_after_start"}, 32'(busy_out), 1);
    for (int k = 0; k < pre_px; k++) drive(1'b1, 1'b0, rand_luma(), 1'b0);
    for (int f = 0; f < WIDTH; f++) begin
      for (int i = 0; i < lens[f]; i++) begin
        logic [LW-1:0] luma;
        if (f == WIDTH-1 && i >= DEPTH) break;
        if (f == abort_frame && i == abort_px) begin
          #2;
          rst_in = 1'b0;
          #1;
          check_reset_outputs({name, "_async_rst"});
          sb.delete();
          repeat (2) @(posedge clk_in);
          @(negedge clk_in);
          rst_in = 1'b1;
          @(posedge clk_in);
          #1;
          check({name, "_no_done_on_reset"}, done_cnt, done_before);
          check({name, "_busy_after_reset"}, 32'(busy_out), 0);
          return;
        end
        luma = pick_luma(mode, f, i);
        if (i < DEPTH) sb.push_back(expect_px(f, i, luma));
        drive(1'b1, i == 0, luma, gaps && f == 1 && i == 2);
        if (gaps) drive(1'b0, 1'($urandom_range(0, 1)), rand_luma(), 1'b0);
      end
    end
    if (lens[WIDTH-1] < DEPTH) begin
      exp_t e;
      e = '{req: 1'b0, done: 1'b1, addr: 0, summand: 0, rtype: 0, frame: 0};
      sb.push_back(e);
      drive(1'b1, 1'b1, rand_luma(), 1'b0);
    end
    repeat (2) drive(1'b0, 1'b0, '0, 1'b0);
    check({name, "_busy_after_done"}, 32'(busy_out), 0);
    check({name, "_done_count"}, done_cnt, done_before + 1);
    check({name, "_pending_expectations"}, sb.size(), 0);
  endtask

  initial begin
    int lens[WIDTH];
    bus.pixel_valid_in = 1'b0;
    bus.frame_start_in = 1'b0;
    bus.pixel_luma_in  = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("por");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    drive(1'b1, 1'b1, 8'd255, 1'b0);
    check("idle_ignores_pixels", 32'(bus.request_valid_out), 0);

    lens = '{16, 16, 16, 16};
    run_capture("basic", lens, 0, 1'b0, 0, -1, 0);
    run_capture("arming", lens, 1, 1'b0, 11, -1, 0);
    run_capture("ambiguous", lens, 2, 1'b0, 0, -1, 0);
    lens = '{20, 16, 16, 10};
    run_capture("long_short", lens, 1, 1'b0, 0, -1, 0);
    lens = '{16, 16, 16, 16};
    run_capture("gaps", lens, 1, 1'b1, 3, -1, 0);
    run_capture("reset_mid", lens, 1, 1'b0, 0, 2, 7);
    run_capture("after_reset", lens, 1, 1'b0, 0, -1, 0);

    thresh_lo_in = 8'd220;
    thresh_hi_in = 8'd100;
    run_capture("overlap_thresh", lens, 1, 1'b0, 0, -1, 0);
    thresh_lo_in = LW'(LO);
    thresh_hi_in = LW'(HI);

    repeat (3) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
